iqueue: RTL and testbench
=========================

# iqueue

Instruction queue between the fetch stage and the decoder. It accepts the registered 64-bit fetch word, its PC and a valid strobe, and stores the word as 16-bit halfword parcels. It realigns the parcels across word boundaries and presents one RVC (16-bit) or RV (32-bit) instruction per cycle with its PC to decode under a valid/ready handshake. It also back-pressures the PC generator early enough to absorb in-flight fetches.

## Interface
- DW, 64, fetch word width; only 64 is supported.
- DEPTH, 16, queue capacity in halfwords; must be a power of two and at least 16.
- CLK  input  1  single clock; all state on the rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- fetch_pc  input  64  PC of the first valid halfword in fetch_instr; bit 0 ignored.
- fetch_instr  input  DW  the aligned doubleword containing fetch_pc.
- fetch_valid  input  1  fetch word present this cycle.
- flush  input  1  synchronous pipeline flush (redirect).
- iq_stall  output  1  to pcGen: stop issuing fetch requests.
- iq_overflow  output  1  sticky error: a valid fetch word was dropped for lack of space.
- iq_instr  output  32  instruction to decode; an RVC instruction is zero-extended into bits [31:16].
- iq_pc  output  64  PC of iq_instr.
- iq_isRVC  output  1  iq_instr is a 16-bit instruction.
- iq_valid  output  1  iq_instr, iq_pc and iq_isRVC are valid.
- iq_ready  input  1  decode consumes the instruction this cycle.

## Operation
**State**
- Circular halfword buffer of DEPTH entries, a read pointer, a write pointer and a halfword count (0..DEPTH).
- head_pc register holding the PC of the halfword at the read pointer.
- Sticky overflow flag.

**Write**
- When fetch_valid & ~flush, the block pushes n = 4 - fetch_pc[2:1] halfwords: fetch_instr halfwords fetch_pc[2:1]..3, in ascending order.
- Halfwords below fetch_pc[2:1] are discarded.
- A push is accepted only if (DEPTH - count) >= n.
- If the push is not accepted, the word is dropped entirely, the overflow flag is set, and no other state changes.

**Head PC**
- head_pc loads fetch_pc when a push is accepted into a queue whose post-pop count is 0.
- Otherwise head_pc advances by 2 (RVC pop) or 4 (RV pop).
- Upstream guarantees that consecutive fetch words are contiguous between flushes.

**Decode**
- h0 and h1 are the halfwords at the read pointer and read pointer + 1, modulo DEPTH.
- iq_isRVC = (h0[1:0] != 2'b11).
- iq_valid = ~flush & (count >= 1) & (iq_isRVC | count >= 2).
- iq_instr = iq_isRVC ? {16'b0, h0} : {h1, h0}.
- iq_pc = head_pc.

**Pop**
- When iq_valid & iq_ready, the block removes 1 (RVC) or 2 (RV) halfwords.
- A pop and a push in the same cycle are both applied: count_next = count - pop + push.
- Space for the push is checked against the pre-pop count.

**Stall and flush**
- iq_stall = (count > DEPTH - 8), i.e. fewer than 8 free halfwords (two full words in flight).
- flush clears the pointers and count to 0 and clears the overflow flag.
- Any fetch_valid in the flush cycle is dropped, and no pop occurs in that cycle.
- head_pc is left unchanged by flush; it reloads on the next push.

**Wrap-around**
- Pointers wrap modulo DEPTH.
- An RV instruction whose two halves straddle the buffer end is assembled correctly.

## Timing
**Reset values**
- count, pointers, iq_valid, iq_isRVC, iq_stall and iq_overflow are 0.
- Buffer entries are 0, so iq_instr = 0.
- head_pc and iq_pc = 64'h80000000.

**Latency**
- Write-to-output latency is 1 cycle: a word pushed on edge N can appear on iq_valid after edge N, with no combinational bypass.
- iq_valid, iq_instr, iq_pc and iq_isRVC are combinational from registered state and flush only; they never depend on iq_ready.
- iq_stall is combinational from count; it asserts the cycle after the push that crosses the threshold.

**Reset mid-operation**
- Asserting RSTn low asynchronously returns all state to the reset values immediately, regardless of the handshake in progress.

## Test plan
- **Four RVC instructions:** aligned word at fetch_pc 0x80000000 holding four RVC instructions, iq_ready=1 → iq_valid for 4 consecutive cycles with iq_pc 0x80000000, 0x80000002, 0x80000004, 0x80000006, iq_isRVC=1; then iq_valid=0.
- **RV instruction split across words:** fetch_pc 0x80000006 with halfword 3 = 0x0513 (low half of an RV instruction) → iq_valid stays 0. Next word at 0x80000008 with halfword 0 = 0x0010 → iq_instr 0x00100513, iq_pc 0x80000006, iq_isRVC=0; the next instruction has iq_pc 0x8000000A.
- **Fill, stall and overflow:** iq_ready=0 with aligned pushes. After 2 words count=8 and iq_stall=0; after 3 words iq_stall=1; after 4 words count=16. A 5th word is dropped, iq_overflow=1 and the contents are unchanged.
- **Flush:** flush asserted together with fetch_valid while count=6 → next cycle count=0, iq_valid=0, iq_overflow=0. A following word at 0x80001002 yields iq_pc 0x80001002 and 3 halfwords queued.
- **Simultaneous pop and push at the wrap boundary:** read pointer at entry 15 holding the low half of an RV instruction, push plus pop in the same cycle → the RV instruction is assembled from entries 15 and 0, and count updates as count - 2 + 4.
- **Reset mid-operation:** RSTn low mid-stream with count=10 → immediate count 0, iq_valid 0, iq_pc 0x80000000.

Source files
------------

// File: rtl/iqueue_if.sv
// Fetch-to-decode bundle for the instruction queue: the fetch word coming in,
// the realigned instruction going out, and the pcGen back-pressure.
interface iqueue_if #(
  parameter int DW = 64
);
  logic [63:0]   fetch_pc;
  logic [DW-1:0] fetch_instr;
  logic          fetch_valid;
  logic          flush;
  logic          iq_stall;
  logic          iq_overflow;
  logic [31:0]   iq_instr;
  logic [63:0]   iq_pc;
  logic          iq_isRVC;
  logic          iq_valid;
  logic          iq_ready;

  // Environment side: drives fetch words, flush and decode readiness.
  modport master (
    output fetch_pc, fetch_instr, fetch_valid, flush, iq_ready,
    input  iq_stall, iq_overflow, iq_instr, iq_pc, iq_isRVC, iq_valid
  );

  // Queue side.
  modport slave (
    input  fetch_pc, fetch_instr, fetch_valid, flush, iq_ready,
    output iq_stall, iq_overflow, iq_instr, iq_pc, iq_isRVC, iq_valid
  );
endinterface

// File: rtl/iqueue.sv
// Instruction queue: stores fetch words as 16-bit parcels in a circular
// buffer and hands one RVC or RV instruction per cycle to decode.
module iqueue #(
  parameter int DW    = 64,
  parameter int DEPTH = 16
) (
  input  logic  CLK,
  input  logic  RSTn,
  iqueue_if.slave io
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NHW = DW / 16;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_C  = CW'(DEPTH - 8);
  localparam logic [63:0]   RESET_PC = 64'h8000_0000;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   head_pc_q, head_pc_d;
  logic          overflow_q, overflow_d;

  logic [15:0]   h0, h1;
  logic [15:0]   fetch_hw [NHW];
  logic          is_rvc, valid, pop, push_req, push_ok;
  logic [1:0]    off, src;
  logic [CW-1:0] pop_n, push_n, post_pop;

  // Decode the head of the queue; outputs depend only on state and flush.
  always_comb begin
    h0             = mem_q[rd_ptr_q];
    h1             = mem_q[rd_ptr_q + PW'(1)];
    is_rvc         = (h0[1:0] != 2'b11);
    valid          = ~io.flush & (count_q != '0) & (is_rvc | (count_q >= CW'(2)));
    io.iq_valid    = valid;
    // An empty queue reports no instruction type, keeping isRVC low from reset.
    io.iq_isRVC    = is_rvc & (count_q != '0);
    io.iq_instr    = is_rvc ? {16'h0000, h0} : {h1, h0};
    io.iq_pc       = head_pc_q;
    io.iq_stall    = (count_q > STALL_C);
    io.iq_overflow = overflow_q;
  end

  // Next-state: push realigned parcels, pop the decoded instruction, flush.
  always_comb begin
    // NOTE: every variable gets a default here so no path infers a latch.
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    head_pc_d  = head_pc_q;
    overflow_d = overflow_q;
    src        = '0;

    for (int k = 0; k < NHW; k++) fetch_hw[k] = io.fetch_instr[16*k +: 16];

    off      = io.fetch_pc[2:1];
    push_n   = CW'(3'd4 - {1'b0, off});
    pop      = valid & io.iq_ready;
    pop_n    = pop ? (is_rvc ? CW'(1) : CW'(2)) : '0;
    push_req = io.fetch_valid & ~io.flush;
    // Space is judged against the pre-pop count.
    push_ok  = push_req & ((DEPTH_C - count_q) >= push_n);
    post_pop = count_q - pop_n;

    if (io.flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_req && !push_ok) overflow_d = 1'b1;
      if (push_ok) begin
        for (int i = 0; i < NHW; i++) begin
          if (CW'(i) < push_n) begin
            src = off + 2'(i);
            mem_d[wr_ptr_q + PW'(i)] = fetch_hw[src];
          end
        end
        wr_ptr_d = wr_ptr_q + PW'(push_n);
      end
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      count_d  = post_pop + (push_ok ? push_n : '0);
      // A push into a queue that drains empty this cycle restarts the PC.
      if (push_ok && post_pop == '0) head_pc_d = io.fetch_pc & ~64'd1;
      else if (pop)                  head_pc_d = head_pc_q + (is_rvc ? 64'd2 : 64'd4);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      // NOTE: the parcel buffer is reset too, so iq_instr reads 0 out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_pc_q  <= RESET_PC;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_pc_q  <= head_pc_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_iqueue.sv
// Scoreboard bench for iqueue: directed fetch words push expected
// instructions into a queue; a negedge monitor checks every handshake.
module tb_iqueue;
  logic clk;
  logic rst_n;

  iqueue_if #(.DW(64)) bus ();

  iqueue #(.DW(64), .DEPTH(16)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .io   (bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        rvc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_hw(input logic [63:0] pc, input logic [15:0] hw);
    exp_q.push_back('{instr: {16'h0000, hw}, pc: pc, rvc: 1'b1});
  endtask

  task automatic expect_rv(input logic [63:0] pc, input logic [31:0] ins);
    exp_q.push_back('{instr: ins, pc: pc, rvc: 1'b0});
  endtask

  // Present one fetch word for exactly one rising edge; returns 1 time unit after it.
  task automatic push_word(input logic [63:0] pc, input logic [63:0] w);
    bus.fetch_pc    = pc;
    bus.fetch_instr = w;
    bus.fetch_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.fetch_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.iq_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Word of four RVC parcels tagged with a running index in the upper byte.
  function automatic logic [63:0] rvc_word(input int base);
    logic [63:0] w;
    for (int j = 0; j < 4; j++) w[16*j +: 16] = {8'(base + j), 8'h01};
    return w;
  endfunction

  // Monitor: compare each accepted instruction with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.iq_valid && bus.iq_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got pc %h instr %h expected nothing", bus.iq_pc, bus.iq_instr);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_instr", 64'(bus.iq_instr), 64'(mon_e.instr));
        check("mon_pc", bus.iq_pc, mon_e.pc);
        check("mon_isRVC", 64'(bus.iq_isRVC), 64'(mon_e.rvc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] w;
    clk             = 1'b0;
    rst_n           = 1'b0;
    bus.fetch_pc    = '0;
    bus.fetch_instr = '0;
    bus.fetch_valid = 1'b0;
    bus.flush       = 1'b0;
    bus.iq_ready    = 1'b0;

    // Reset values.
    #12;
    check("rst_valid", 64'(bus.iq_valid), 64'd0);
    check("rst_isRVC", 64'(bus.iq_isRVC), 64'd0);
    check("rst_stall", 64'(bus.iq_stall), 64'd0);
    check("rst_overflow", 64'(bus.iq_overflow), 64'd0);
    check("rst_instr", 64'(bus.iq_instr), 64'd0);
    check("rst_pc", bus.iq_pc, 64'h8000_0000);
    check("rst_count", 64'(dut.count_q), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four RVC instructions in one aligned word.
    bus.iq_ready = 1'b1;
    expect_hw(64'h8000_0000, 16'h4501);
    expect_hw(64'h8000_0002, 16'h4585);
    expect_hw(64'h8000_0004, 16'h4609);
    expect_hw(64'h8000_0006, 16'h0001);
    push_word(64'h8000_0000, {16'h0001, 16'h4609, 16'h4585, 16'h4501});
    drain("t1");
    check("t1_idle_valid", 64'(bus.iq_valid), 64'd0);

    // RV instruction split across two fetch words.
    expect_rv(64'h8000_0006, 32'h0010_0513);
    expect_hw(64'h8000_000A, 16'h4505);
    expect_rv(64'h8000_000C, 32'h0040_00b3);
    push_word(64'h8000_0006, {16'h0513, 16'hAAAA, 16'hBBBB, 16'hCCCC});
    check("t2_half_valid", 64'(bus.iq_valid), 64'd0);
    check("t2_half_count", 64'(dut.count_q), 64'd1);
    push_word(64'h8000_0008, {16'h0040, 16'h00b3, 16'h4505, 16'h0010});
    drain("t2");

    // Fill, stall threshold, overflow.
    bus.iq_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) expect_hw(64'h8000_0100 + 64'(8*k + 2*j), {8'(4*k + j), 8'h01});
      push_word(64'h8000_0100 + 64'(8*k), rvc_word(4*k));
      if (k == 1) begin
        check("t3_count8", 64'(dut.count_q), 64'd8);
        check("t3_stall_at8", 64'(bus.iq_stall), 64'd0);
      end else if (k == 2) begin
        check("t3_stall_at12", 64'(bus.iq_stall), 64'd1);
      end else if (k == 3) begin
        check("t3_count16", 64'(dut.count_q), 64'd16);
      end
    end
    push_word(64'h8000_0120, {4{16'hFF01}});
    check("t3_overflow", 64'(bus.iq_overflow), 64'd1);
    check("t3_full_count", 64'(dut.count_q), 64'd16);
    check("t3_head_pc", bus.iq_pc, 64'h8000_0100);
    check("t3_head_instr", 64'(bus.iq_instr), 64'h0000_0001);
    drain("t3");
    check("t3_overflow_sticky", 64'(bus.iq_overflow), 64'd1);

    // Flush together with a fetch word.
    bus.iq_ready = 1'b0;
    push_word(64'h8000_0200, {4{16'h0001}});
    push_word(64'h8000_020C, {4{16'h0001}});
    check("t4_count6", 64'(dut.count_q), 64'd6);
    bus.flush       = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 64'h8000_0210;
    #1;
    check("t4_valid_in_flush", 64'(bus.iq_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    check("t4_count0", 64'(dut.count_q), 64'd0);
    check("t4_valid0", 64'(bus.iq_valid), 64'd0);
    check("t4_overflow_clr", 64'(bus.iq_overflow), 64'd0);
    expect_hw(64'h8000_1002, 16'h4501);
    expect_rv(64'h8000_1004, 32'h0010_0513);
    push_word(64'h8000_1002, {16'h0010, 16'h0513, 16'h4501, 16'hDEAD});
    check("t4_count3", 64'(dut.count_q), 64'd3);
    check("t4_pc", bus.iq_pc, 64'h8000_1002);
    drain("t4");

    // Push plus pop while an RV instruction straddles entries 15 and 0.
    bus.iq_ready = 1'b0;
    do_flush();
    for (int k = 0; k < 4; k++) begin
      w = rvc_word(4*k);
      if (k == 3) w[63:48] = 16'h0513;
      for (int j = 0; j < 4; j++)
        if (4*k + j < 15) expect_hw(64'h8000_0300 + 64'(8*k + 2*j), {8'(4*k + j), 8'h01});
      push_word(64'h8000_0300 + 64'(8*k), w);
    end
    check("t5_full", 64'(dut.count_q), 64'd16);
    drain("t5_pre");
    check("t5_rdptr15", 64'(dut.rd_ptr_q), 64'd15);
    check("t5_count1", 64'(dut.count_q), 64'd1);
    check("t5_half_valid", 64'(bus.iq_valid), 64'd0);
    bus.iq_ready = 1'b0;
    expect_rv(64'h8000_031E, 32'h0010_0513);
    expect_hw(64'h8000_0322, 16'h4505);
    expect_hw(64'h8000_0324, 16'h4509);
    expect_hw(64'h8000_0326, 16'h450d);
    push_word(64'h8000_0320, {16'h450d, 16'h4509, 16'h4505, 16'h0010});
    check("t5_count5", 64'(dut.count_q), 64'd5);
    for (int j = 0; j < 4; j++) expect_hw(64'h8000_0328 + 64'(2*j), {8'(32 + j), 8'h01});
    bus.iq_ready = 1'b1;
    push_word(64'h8000_0328, rvc_word(32));
    check("t5_pushpop_count", 64'(dut.count_q), 64'd7);
    check("t5_pc_after_rv", bus.iq_pc, 64'h8000_0322);
    drain("t5");

    // Asynchronous reset in the middle of a stream.
    bus.iq_ready = 1'b0;
    do_flush();
    push_word(64'h8000_0400, {4{16'h0001}});
    push_word(64'h8000_0408, {4{16'h0001}});
    push_word(64'h8000_0414, {4{16'h0001}});
    check("t6_count10", 64'(dut.count_q), 64'd10);
    check("t6_stall_pre", 64'(bus.iq_stall), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_count0", 64'(dut.count_q), 64'd0);
    check("t6_valid0", 64'(bus.iq_valid), 64'd0);
    check("t6_pc", bus.iq_pc, 64'h8000_0000);
    check("t6_stall0", 64'(bus.iq_stall), 64'd0);
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_post_valid", 64'(bus.iq_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
